reg_operand_fetch: RTL and testbench

- Reader-side companion to the 32x32 register bank: drives the bank's two combinational read ports and registers the operands for the execute stage.
- Keeps a per-register busy scoreboard of in-flight writers and stalls issue on RAW or WAW hazards.
- Forwards same-cycle writeback data, because the bank updates only at the next clock edge.
- Sits between decode and execute in the pipelined KGP-RISC core.

---
 rtl/reg_operand_fetch_if.sv | 44 ++++
 rtl/reg_operand_fetch.sv | 113 +++++++++++
 tb/tb_reg_operand_fetch.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_operand_fetch_if.sv
// Decode/bank/writeback/execute signal bundle around the operand fetch stage.
// master = surrounding pipeline, slave = reg_operand_fetch.
interface reg_operand_fetch_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        in_sr1;
    logic [AW-1:0]        in_sr2;
    logic                 in_use1;
    logic                 in_use2;
    logic [AW-1:0]        in_dr;
    logic                 in_wen;
    logic [AW-1:0]        rf_sr1;
    logic [AW-1:0]        rf_sr2;
    logic [DW-1:0]        rf_rdata1;
    logic [DW-1:0]        rf_rdata2;
    logic                 wb_write;
    logic [AW-1:0]        wb_dr;
    logic [DW-1:0]        wb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_op1;
    logic [DW-1:0]        out_op2;
    logic [AW-1:0]        out_dr;
    logic                 out_wen;
    logic                 flush;
    logic [(1<<AW)-1:0]   busy_vec;

    modport master (
        output in_valid, in_sr1, in_sr2, in_use1, in_use2, in_dr, in_wen,
        output rf_rdata1, rf_rdata2, wb_write, wb_dr, wb_data, out_ready, flush,
        input  in_ready, rf_sr1, rf_sr2, out_valid, out_op1, out_op2, out_dr,
        input  out_wen, busy_vec
    );

    modport slave (
        input  in_valid, in_sr1, in_sr2, in_use1, in_use2, in_dr, in_wen,
        input  rf_rdata1, rf_rdata2, wb_write, wb_dr, wb_data, out_ready, flush,
        output in_ready, rf_sr1, rf_sr2, out_valid, out_op1, out_op2, out_dr,
        output out_wen, busy_vec
    );
endinterface

// File: rtl/reg_operand_fetch.sv
// Operand fetch stage: reads the register bank, forwards writeback data,
// tracks in-flight writers in a busy scoreboard and stalls on RAW/WAW hazards.
module reg_operand_fetch #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_operand_fetch_if.slave     bus
);
    localparam int NR = 1 << AW;

    logic [NR-1:0] busy_reg;
    logic [NR-1:0] busy_next;
    logic [NR-1:0] clr;
    logic [NR-1:0] set;
    logic [NR-1:0] fclr;
    logic [NR-1:0] busy_eff;

    logic          out_valid_reg;
    logic [DW-1:0] out_op1_reg;
    logic [DW-1:0] out_op2_reg;
    logic [AW-1:0] out_dr_reg;
    logic          out_wen_reg;

    logic          hazard;
    logic          in_ready;
    logic          accept;
    logic [DW-1:0] op1_next;
    logic [DW-1:0] op2_next;

    // The bank only commits a writeback at the next edge, so a same-cycle
    // write must be forwarded here; register 0 always reads as zero.
    function automatic logic [DW-1:0] select_operand(
        input logic [AW-1:0] sr,
        input logic [DW-1:0] rdata,
        input logic          wr,
        input logic [AW-1:0] wdr,
        input logic [DW-1:0] wdata
    );
        if (sr == '0)
            return '0;
        else if (wr && wdr == sr)
            return wdata;
        else
            return rdata;
    endfunction

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign clr[gi]       = 1'b0;
                assign set[gi]       = 1'b0;
                assign fclr[gi]      = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign clr[gi]  = bus.wb_write && (bus.wb_dr == AW'(gi));
                assign set[gi]  = accept && bus.in_wen && (bus.in_dr == AW'(gi));
                assign fclr[gi] = bus.flush && out_valid_reg && out_wen_reg &&
                                  (out_dr_reg == AW'(gi));
                // A new writer claiming the register outranks any clear.
                assign busy_next[gi] = set[gi] || (busy_reg[gi] && !clr[gi] && !fclr[gi]);
            end
        end
    endgenerate

    assign busy_eff = busy_reg & ~clr;

    always_comb begin
        hazard = (bus.in_use1 && busy_eff[bus.in_sr1]) ||
                 (bus.in_use2 && busy_eff[bus.in_sr2]) ||
                 (bus.in_wen  && busy_eff[bus.in_dr]);
        in_ready = !reset && !hazard && (!out_valid_reg || bus.out_ready) && !bus.flush;
        accept   = bus.in_valid && in_ready;
        op1_next = select_operand(bus.in_sr1, bus.rf_rdata1, bus.wb_write, bus.wb_dr, bus.wb_data);
        op2_next = select_operand(bus.in_sr2, bus.rf_rdata2, bus.wb_write, bus.wb_dr, bus.wb_data);
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_op1_reg   <= '0;
            out_op2_reg   <= '0;
            out_dr_reg    <= '0;
            out_wen_reg   <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_op1_reg   <= op1_next;
            out_op2_reg   <= op2_next;
            out_dr_reg    <= bus.in_dr;
            out_wen_reg   <= bus.in_wen && (bus.in_dr != '0);
        end else if (bus.flush || bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rf_sr1    = bus.in_sr1;
    assign bus.rf_sr2    = bus.in_sr2;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_op1   = out_op1_reg;
    assign bus.out_op2   = out_op2_reg;
    assign bus.out_dr    = out_dr_reg;
    assign bus.out_wen   = out_wen_reg;
    assign bus.busy_vec  = busy_reg;
endmodule

// File: tb/tb_reg_operand_fetch.sv
// Self-checking bench for reg_operand_fetch: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_reg_operand_fetch;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reg_operand_fetch_if #(.DW(DW), .AW(AW)) bus ();

    reg_operand_fetch #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state: busy table and operand register contents.
    bit            m_busy[NR];
    bit            m_valid;
    bit            m_wen;
    logic [AW-1:0] m_dr;
    logic [DW-1:0] m_op1;
    logic [DW-1:0] m_op2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [AW-1:0] r);
        return m_busy[r] && !(bus.wb_write && bus.wb_dr == r);
    endfunction

    function automatic logic [DW-1:0] operand(input logic [AW-1:0] sr, input logic [DW-1:0] rd);
        if (sr == 0) return '0;
        if (bus.wb_write && bus.wb_dr == sr) return bus.wb_data;
        return rd;
    endfunction

    task automatic set_idle();
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sr1    = '0;
        bus.in_sr2    = '0;
        bus.in_use1   = 1'b0;
        bus.in_use2   = 1'b0;
        bus.in_dr     = '0;
        bus.in_wen    = 1'b0;
        bus.rf_rdata1 = '0;
        bus.rf_rdata2 = '0;
        bus.wb_write  = 1'b0;
        bus.wb_dr     = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
    endtask

    task automatic issue(input int s1, input int s2, input bit u1, input bit u2,
                         input int d, input bit w);
        bus.in_valid = 1'b1;
        bus.in_sr1   = AW'(s1);
        bus.in_sr2   = AW'(s2);
        bus.in_use1  = u1;
        bus.in_use2  = u2;
        bus.in_dr    = AW'(d);
        bus.in_wen   = w;
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic cycle();
        bit            haz, exp_ready, acc;
        logic [DW-1:0] e1, e2;
        logic [NR-1:0] ev;
        #1;
        haz = (bus.in_use1 && pending(bus.in_sr1)) ||
              (bus.in_use2 && pending(bus.in_sr2)) ||
              (bus.in_wen  && pending(bus.in_dr));
        exp_ready = !reset && !haz && (!m_valid || bus.out_ready) && !bus.flush;
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("rf_sr1", 32'(bus.rf_sr1), 32'(bus.in_sr1));
        check("rf_sr2", 32'(bus.rf_sr2), 32'(bus.in_sr2));
        acc = bus.in_valid && exp_ready;
        e1  = operand(bus.in_sr1, bus.rf_rdata1);
        e2  = operand(bus.in_sr2, bus.rf_rdata2);
        if (reset) begin
            foreach (m_busy[r]) m_busy[r] = 1'b0;
            m_valid = 0; m_wen = 0; m_dr = '0; m_op1 = '0; m_op2 = '0;
        end else begin
            if (bus.wb_write) m_busy[bus.wb_dr] = 1'b0;
            if (bus.flush && m_valid && m_wen) m_busy[m_dr] = 1'b0;
            if (acc && bus.in_wen && bus.in_dr != 0) m_busy[bus.in_dr] = 1'b1;
            m_busy[0] = 1'b0;
            if (acc) begin
                m_valid = 1; m_op1 = e1; m_op2 = e2; m_dr = bus.in_dr;
                m_wen = bus.in_wen && (bus.in_dr != 0);
            end else if (bus.flush || bus.out_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) ev[r] = m_busy[r];
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("busy_vec", 32'(bus.busy_vec), 32'(ev));
        if (m_valid || reset) begin
            check("out_op1", bus.out_op1, m_op1);
            check("out_op2", bus.out_op2, m_op2);
            check("out_dr", 32'(bus.out_dr), 32'(m_dr));
            check("out_wen", 32'(bus.out_wen), 32'(m_wen));
        end
        if (acc)
            $display("t=%0t accept dr=%0d wen=%0d op1=%h op2=%h busy=%h",
                     $time, bus.out_dr, bus.out_wen, bus.out_op1, bus.out_op2, bus.busy_vec);
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        cycle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy_vec), 32'd0);

        // Basic issue with both sources read.
        set_idle();
        issue(3, 4, 1, 1, 5, 1);
        bus.rf_rdata1 = 32'd10;
        bus.rf_rdata2 = -32'sd2;
        cycle();
        check("t1_op1", bus.out_op1, 32'd10);
        check("t1_op2", bus.out_op2, 32'hFFFF_FFFE);
        check("t1_dr", 32'(bus.out_dr), 32'd5);
        check("t1_busy5", 32'(bus.busy_vec[5]), 32'd1);

        // RAW on r5 until its writeback arrives, which is forwarded.
        set_idle();
        issue(5, 0, 1, 0, 6, 0);
        bus.rf_rdata1 = 32'hDEAD_BEEF;
        repeat (2) begin
            #1 check("raw_stall", 32'(bus.in_ready), 32'd0);
            cycle();
        end
        bus.wb_write = 1'b1;
        bus.wb_dr    = 5'd5;
        bus.wb_data  = 32'h1234;
        cycle();
        check("raw_fwd_op1", bus.out_op1, 32'h1234);
        check("raw_busy5", 32'(bus.busy_vec[5]), 32'd0);

        // WAW clears by writeback in the same cycle a new writer sets r7.
        set_idle();
        issue(0, 0, 0, 0, 7, 1);
        cycle();
        issue(0, 0, 0, 0, 7, 1);
        bus.wb_write = 1'b1;
        bus.wb_dr    = 5'd7;
        cycle();
        check("waw_busy7", 32'(bus.busy_vec[7]), 32'd1);
        check("waw_valid", 32'(bus.out_valid), 32'd1);

        // Backpressure holds the entry, then back-to-back reload.
        set_idle();
        bus.out_ready = 1'b0;
        issue(1, 2, 1, 1, 8, 1);
        repeat (3) begin
            cycle();
            check("bp_hold_dr", 32'(bus.out_dr), 32'd7);
        end
        bus.out_ready = 1'b1;
        cycle();
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        check("b2b_dr", 32'(bus.out_dr), 32'd8);

        // Register 0: never busy, never hazards, reads zero.
        set_idle();
        issue(0, 0, 1, 1, 0, 1);
        cycle();
        issue(0, 0, 1, 0, 0, 1);
        bus.rf_rdata1 = 32'hFFFF;
        bus.wb_write  = 1'b1;
        bus.wb_dr     = 5'd0;
        bus.wb_data   = 32'h55;
        cycle();
        check("r0_op1", bus.out_op1, 32'd0);
        check("r0_wen", 32'(bus.out_wen), 32'd0);
        check("r0_busy", 32'(bus.busy_vec[0]), 32'd0);

        // Flush of a held writer releases its scoreboard bit.
        set_idle();
        issue(0, 0, 0, 0, 9, 1);
        cycle();
        set_idle();
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        cycle();
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_busy9", 32'(bus.busy_vec[9]), 32'd0);

        // Reset in the middle of a stall.
        set_idle();
        issue(0, 0, 0, 0, 10, 1);
        cycle();
        issue(10, 0, 1, 0, 11, 1);
        cycle();
        reset = 1'b1;
        cycle();
        check("rst2_busy", 32'(bus.busy_vec), 32'd0);
        set_idle();
        bus.wb_write = 1'b1;
        bus.wb_dr    = 5'd10;
        cycle();
        check("rst2_late_wb", 32'(bus.busy_vec[10]), 32'd0);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 2);
            bus.in_valid  = ($urandom_range(0, 99) < 70);
            bus.in_sr1    = AW'($urandom_range(0, 7));
            bus.in_sr2    = AW'($urandom_range(0, 7));
            bus.in_use1   = 1'($urandom);
            bus.in_use2   = 1'($urandom);
            bus.in_dr     = AW'($urandom_range(0, 7));
            bus.in_wen    = ($urandom_range(0, 99) < 70);
            bus.rf_rdata1 = $urandom;
            bus.rf_rdata2 = $urandom;
            bus.wb_write  = ($urandom_range(0, 99) < 40);
            bus.wb_dr     = AW'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 99) < 70);
            bus.flush     = ($urandom_range(0, 99) < 5);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
